// File: rtl/aes128_iter_ctrl.sv
// Purpose: job sequencer that walks a one-round-per-cycle AES-128 datapath through a single encrypt or decrypt.
// Latency: out_valid rises 12 cycles after the accept edge for encrypt and 22 for decrypt (10 key pre-expansion steps first).
// Backpressure: in_ready only in IDLE. The result is held in DONE until out_ready, and no job is accepted in that release cycle.
// Ports:
//   clk, rst                      clock, async active-high reset
//   in_valid/in_ready             job handshake; in_mode (1=decrypt), in_key, in_data sampled at the handshake
//   out_valid/out_ready           result handshake; out_data mirrors dp_state while out_valid
//   dp_key, dp_din, dp_inv        registered job key, data and mode for the datapath
//   dp_key_load                   handshake-cycle key load strobe
//   dp_kexp_en/dp_load/dp_round_en  one-hot datapath strobes
//   dp_round_idx, dp_final        current round (1..NR, 0 when idle) and last-round flag
//   dp_state                      datapath state register
module aes128_iter_ctrl #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_mode,
  input  logic [128:1] in_key,
  input  logic [128:1] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [128:1] out_data,
  output logic [128:1] dp_key,
  output logic [128:1] dp_din,
  output logic         dp_key_load,
  output logic         dp_kexp_en,
  output logic         dp_load,
  output logic         dp_round_en,
  output logic [4:1]   dp_round_idx,
  output logic         dp_final,
  output logic         dp_inv,
  input  logic [128:1] dp_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_KEXP  = 3'd1,
    S_LOAD  = 3'd2,
    S_ROUND = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [4:1] LP_LAST = 4'(NR);

  state_t       r_state;
  logic [4:1]   r_rnd;
  logic         r_in_ready;
  logic         r_out_valid;
  logic         r_kexp_en;
  logic         r_load;
  logic         r_round_en;
  logic         r_final;
  logic         r_inv;
  logic [4:1]   r_idx;
  logic [128:1] r_key;
  logic [128:1] r_din;
  logic [4:1]   w_rnd_nxt;

  assign w_rnd_nxt = r_rnd + 4'd1;

  // Strobe and index registers are loaded with the values that belong to the
  // state being entered, so each output is aligned with r_state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rnd       <= 4'd0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_kexp_en   <= 1'b0;
      r_load      <= 1'b0;
      r_round_en  <= 1'b0;
      r_final     <= 1'b0;
      r_inv       <= 1'b0;
      r_idx       <= 4'd0;
      r_key       <= '0;
      r_din       <= '0;
    end else begin
      r_kexp_en  <= 1'b0;
      r_load     <= 1'b0;
      r_round_en <= 1'b0;
      r_final    <= 1'b0;
      r_idx      <= 4'd0;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_key      <= in_key;
            r_din      <= in_data;
            r_inv      <= in_mode;
            r_rnd      <= 4'd1;
            r_in_ready <= 1'b0;
            // Decrypt walks the schedule forward to the last round key first.
            if (in_mode) begin
              r_state   <= S_KEXP;
              r_kexp_en <= 1'b1;
              r_idx     <= 4'd1;
            end else begin
              r_state <= S_LOAD;
              r_load  <= 1'b1;
            end
          end
        end
        S_KEXP: begin
          if (r_rnd >= LP_LAST) begin
            r_state <= S_LOAD;
            r_rnd   <= 4'd1;
            r_load  <= 1'b1;
          end else begin
            r_rnd     <= w_rnd_nxt;
            r_kexp_en <= 1'b1;
            r_idx     <= w_rnd_nxt;
          end
        end
        S_LOAD: begin
          r_state    <= S_ROUND;
          r_round_en <= 1'b1;
          r_idx      <= r_rnd;
          r_final    <= (r_rnd >= LP_LAST);
        end
        S_ROUND: begin
          if (r_rnd >= LP_LAST) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
          end else begin
            r_rnd      <= w_rnd_nxt;
            r_round_en <= 1'b1;
            r_idx      <= w_rnd_nxt;
            r_final    <= (w_rnd_nxt >= LP_LAST);
          end
        end
        S_DONE: begin
          // No strobes here, so dp_state (and out_data) stays put.
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_rnd       <= 4'd0;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready     = r_in_ready;
  assign out_valid    = r_out_valid;
  assign out_data     = r_out_valid ? dp_state : '0;
  assign dp_key       = r_key;
  assign dp_din       = r_din;
  // Asserted during the accept cycle so the key register loads on the same edge as dp_key.
  assign dp_key_load  = r_in_ready & in_valid;
  assign dp_kexp_en   = r_kexp_en;
  assign dp_load      = r_load;
  assign dp_round_en  = r_round_en;
  assign dp_round_idx = r_idx;
  assign dp_final     = r_final;
  assign dp_inv       = r_inv;

endmodule

// File: tb/tb_aes128_iter_ctrl.sv
module tb_aes128_iter_ctrl;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         in_mode;
  logic [127:0] in_key;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [127:0] dp_key;
  logic [127:0] dp_din;
  logic         dp_key_load;
  logic         dp_kexp_en;
  logic         dp_load;
  logic         dp_round_en;
  logic [3:0]   dp_round_idx;
  logic         dp_final;
  logic         dp_inv;
  logic [127:0] dp_state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  aes128_iter_ctrl dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_key(in_key), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .dp_key(dp_key), .dp_din(dp_din), .dp_key_load(dp_key_load),
    .dp_kexp_en(dp_kexp_en), .dp_load(dp_load), .dp_round_en(dp_round_en),
    .dp_round_idx(dp_round_idx), .dp_final(dp_final), .dp_inv(dp_inv),
    .dp_state(dp_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural AES round datapath ----------------
  logic [7:0] sbox_t [256];
  logic [7:0] inv_t  [256];

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  initial begin : build_sbox
    logic [7:0] b, p;
    for (int x = 0; x < 256; x++) begin
      p = 8'h01;
      for (int e = 0; e < 254; e++) p = gm(p, 8'(x));
      b = (x == 0) ? 8'h00 : p;
      sbox_t[8'(x)] = b ^ rl(b, 1) ^ rl(b, 2) ^ rl(b, 3) ^ rl(b, 4) ^ 8'h63;
    end
    for (int x = 0; x < 256; x++) inv_t[sbox_t[8'(x)]] = 8'(x);
  end

  function automatic logic [7:0] rcon(input int i);
    case (i)
      1: return 8'h01;  2: return 8'h02;  3: return 8'h04;  4: return 8'h08;
      5: return 8'h10;  6: return 8'h20;  7: return 8'h40;  8: return 8'h80;
      9: return 8'h1b; 10: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    return {sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]], sbox_t[w[31:24]]};
  endfunction

  function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ sub_rot(k[31:0]) ^ {rc, 24'h0};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] key_bwd(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = k[31:0] ^ k[63:32];
    w2 = k[63:32] ^ k[95:64];
    w1 = k[95:64] ^ k[127:96];
    w0 = k[127:96] ^ sub_rot(w3) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s, input logic inv);
    logic [7:0] co [4];
    logic [7:0] a  [4];
    logic [7:0] acc;
    logic [127:0] o;
    if (inv) begin co[0] = 8'd14; co[1] = 8'd11; co[2] = 8'd13; co[3] = 8'd9; end
    else     begin co[0] = 8'd2;  co[1] = 8'd3;  co[2] = 8'd1;  co[3] = 8'd1; end
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) a[j] = s[127 - 8*(4*c + j) -: 8];
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gm(a[j], co[(j - r + 4) % 4]);
        o[127 - 8*(4*c + r) -: 8] = acc;
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] enc_round(input logic [127:0] s, input logic fin);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8*(4*c + r) -: 8] = sbox_t[s[127 - 8*(4*((c + r) % 4) + r) -: 8]];
    if (!fin) o = mix(o, 1'b0);
    return o;
  endfunction

  function automatic logic [127:0] dec_round(input logic [127:0] s, input logic fin, input logic [127:0] k);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8*(4*c + r) -: 8] = inv_t[s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8]];
    o = o ^ k;
    if (!fin) o = mix(o, 1'b1);
    return o;
  endfunction

  // The key register is written on the accept edge, the same edge that
  // captures dp_key, so it samples the job key from the request bus.
  logic [127:0] mdl_key;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_state <= '0;
      mdl_key  <= '0;
    end else if (dp_key_load) begin
      mdl_key <= in_key;
    end else if (dp_kexp_en) begin
      mdl_key <= key_fwd(mdl_key, rcon(int'(dp_round_idx)));
    end else if (dp_load) begin
      dp_state <= dp_din ^ mdl_key;
    end else if (dp_round_en && !dp_inv) begin
      dp_state <= enc_round(dp_state, dp_final) ^ key_fwd(mdl_key, rcon(int'(dp_round_idx)));
      mdl_key  <= key_fwd(mdl_key, rcon(int'(dp_round_idx)));
    end else if (dp_round_en) begin
      dp_state <= dec_round(dp_state, dp_final, key_bwd(mdl_key, rcon(11 - int'(dp_round_idx))));
      mdl_key  <= key_bwd(mdl_key, rcon(11 - int'(dp_round_idx)));
    end
  end

  // ---------------- checking ----------------
  always @(negedge clk) begin
    if (!rst) begin
      total++;
      assert ($onehot0({dp_kexp_en, dp_load, dp_round_en})) else begin
        bad++;
        $display("FAIL strobe_overlap: got kexp=%b load=%b round=%b, required at most one", dp_kexp_en, dp_load, dp_round_en);
      end
      total++;
      assert (!(dp_key_load && !in_ready)) else begin
        bad++;
        $display("FAIL key_load_not_idle: got dp_key_load=1 with in_ready=0, required 0");
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic         mode;
    logic [127:0] key;
    logic [127:0] din;
    logic [127:0] dout;
    int           lat;
  } vec_t;

  vec_t vecs [4];
  int   hs_a, hs_b;

  task automatic reset_chk(input string tag);
    chk({tag, " in_ready"},  128'(in_ready), 128'(1));
    chk({tag, " out_valid"}, 128'(out_valid), 128'(0));
    chk({tag, " out_data"},  out_data, 128'(0));
    chk({tag, " strobes"},   128'({dp_key_load, dp_kexp_en, dp_load, dp_round_en, dp_final}), 128'(0));
    chk({tag, " round_idx"}, 128'(dp_round_idx), 128'(0));
    chk({tag, " dp_inv"},    128'(dp_inv), 128'(0));
    chk({tag, " dp_key"},    dp_key, 128'(0));
    chk({tag, " dp_din"},    dp_din, 128'(0));
  endtask

  // Called at a negedge; the handshake happens on the following posedge.
  task automatic accept(input vec_t v);
    in_valid = 1'b1; in_mode = v.mode; in_key = v.key; in_data = v.din;
    #1;
    chk("accept in_ready", 128'(in_ready), 128'(1));
    chk("accept dp_key_load", 128'(dp_key_load), 128'(1));
    hs_a = cyc;
  endtask

  // Follows one job from the accept edge up to its first out_valid cycle.
  task automatic track(input vec_t v, input bit swap, input vec_t nv);
    int kcnt, rcnt, lat, load_at;
    kcnt = 0; rcnt = 0; lat = 0; load_at = 0;
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("dp_key captured", dp_key, v.key);
        chk("dp_din captured", dp_din, v.din);
        chk("dp_inv", 128'(dp_inv), 128'(v.mode));
        if (swap) begin in_mode = nv.mode; in_key = nv.key; in_data = nv.din; end
        else in_valid = 1'b0;
      end
      chk("in_ready busy", 128'(in_ready), 128'(0));
      if (dp_kexp_en) begin
        kcnt++;
        chk("kexp idx", 128'(dp_round_idx), 128'(kcnt));
      end
      if (dp_load) begin
        load_at = c;
        chk("kexp before load", 128'(kcnt), 128'(v.mode ? 10 : 0));
        chk("load idx", 128'(dp_round_idx), 128'(0));
      end
      if (dp_round_en) begin
        rcnt++;
        chk("round idx", 128'(dp_round_idx), 128'(rcnt));
        chk("final flag", 128'(dp_final), 128'(rcnt == 10));
      end
      if (out_valid) lat = c;
    end
    chk("latency", 128'(lat), 128'(v.lat));
    chk("load cycle", 128'(load_at), 128'(v.lat - 11));
    chk("round count", 128'(rcnt), 128'(10));
    chk("out_data", out_data, v.dout);
    chk("dp_inv at done", 128'(dp_inv), 128'(v.mode));
  endtask

  initial begin
    vecs[0] = '{1'b0, 128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a, 12};
    vecs[1] = '{1'b1, 128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                128'h00112233445566778899aabbccddeeff, 22};
    vecs[2] = '{1'b0, 128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
                128'h3925841d02dc09fbdc118597196a0b32, 12};
    vecs[3] = '{1'b1, 128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32,
                128'h3243f6a8885a308d313198a2e0370734, 22};

    rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_key = '0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset_chk("reset");
    rst = 1'b0;

    // Table of single jobs, consumer always ready.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      accept(vecs[i]);
      track(vecs[i], 1'b0, vecs[i]);
      @(negedge clk);
      chk("out_valid single cycle", 128'(out_valid), 128'(0));
      chk("in_ready after done", 128'(in_ready), 128'(1));
    end

    // Back-pressure with a second job waiting on the request bus.
    @(negedge clk);
    out_ready = 1'b0;
    accept(vecs[0]);
    track(vecs[0], 1'b1, vecs[1]);
    for (int h = 0; h < 5; h++) begin
      @(negedge clk);
      chk("bp out_valid", 128'(out_valid), 128'(1));
      chk("bp out_data", out_data, vecs[0].dout);
      chk("bp in_ready", 128'(in_ready), 128'(0));
      chk("bp no key_load", 128'(dp_key_load), 128'(0));
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp release out_valid", 128'(out_valid), 128'(0));
    chk("bp second accept in_ready", 128'(in_ready), 128'(1));
    chk("bp second accept key_load", 128'(dp_key_load), 128'(1));
    track(vecs[1], 1'b0, vecs[1]);
    @(negedge clk);

    // Reset in the middle of an encrypt.
    @(negedge clk);
    accept(vecs[2]);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid-job round active", 128'(dp_round_en), 128'(1));
    rst = 1'b1;
    #1;
    reset_chk("midrst");
    @(negedge clk);
    rst = 1'b0;
    begin
      int seen;
      seen = 0;
      repeat (25) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      chk("no out_valid after reset", 128'(seen), 128'(0));
    end
    accept(vecs[2]);
    track(vecs[2], 1'b0, vecs[2]);
    @(negedge clk);

    // Back-to-back: encrypt then decrypt with in_valid held high.
    @(negedge clk);
    accept(vecs[0]);
    track(vecs[0], 1'b1, vecs[3]);
    @(negedge clk);
    hs_b = cyc;
    chk("b2b accept in_ready", 128'(in_ready), 128'(1));
    chk("b2b accept key_load", 128'(dp_key_load), 128'(1));
    chk("b2b handshake spacing", 128'(hs_b - hs_a), 128'(13));
    track(vecs[3], 1'b0, vecs[3]);
    @(negedge clk);
    chk("b2b final out_valid", 128'(out_valid), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
